// File: rtl/fm_demod16_if.sv
// Sample bus between the serial CORDIC (vector-mode results) and the FM demodulator,
// including the demodulated outputs returned to the downstream audio path.
interface fm_demod16_if;
  logic        [15:0] xi;
  logic signed [15:0] zi;
  logic               mi;
  logic               iv;
  logic        [15:0] sq_thr;
  logic signed [15:0] fo;
  logic        [15:0] ao;
  logic               sq;
  logic               ov;

  modport master (
    output xi, zi, mi, iv, sq_thr,
    input  fo, ao, sq, ov
  );

  modport slave (
    input  xi, zi, mi, iv, sq_thr,
    output fo, ao, sq, ov
  );
endinterface

// File: rtl/fm_demod16.sv
// FM discriminator, AM magnitude and hysteretic squelch on CORDIC vector-mode results.
// Optional single-pole de-emphasis on the discriminator output when FM_DEEMPH_EN is defined.
module fm_demod16 #(
  parameter int          HOLD = 1024,
  parameter logic [15:0] HYST = 16'h0100,
  parameter int          K    = 4
) (
  input  logic         clk,
  input  logic         rst,
  fm_demod16_if.slave  bus
);
  localparam int              DATA_W  = 16;
  localparam logic [DATA_W-1:0] HOLD_M1 = DATA_W'(HOLD - 1);

  typedef enum logic [1:0] {SQ_CLOSED, SQ_OPEN, SQ_HANG} sq_state_e;

  // Threshold plus hysteresis, saturated so a high threshold cannot wrap to a low open level.
  function automatic logic [DATA_W-1:0] sat_open(input logic [DATA_W-1:0] thr,
                                                 input logic [DATA_W-1:0] hyst);
    logic [DATA_W:0] s;
    s = {1'b0, thr} + {1'b0, hyst};
    return s[DATA_W] ? '1 : s[DATA_W-1:0];
  endfunction

  sq_state_e                 state_q, state_d;
  logic        [DATA_W-1:0]  cnt_q, cnt_d;
  logic signed [DATA_W-1:0]  zprev_q;
  logic                      primed_q;
  logic signed [DATA_W-1:0]  fo_q;
  logic        [DATA_W-1:0]  ao_q;
  logic                      sq_q;
  logic                      ov_q;

  logic                      accept;
  logic        [DATA_W-1:0]  open_lvl;
  logic signed [DATA_W-1:0]  d;
  logic signed [DATA_W-1:0]  fo_new;

  assign accept   = bus.iv & ~bus.mi;
  assign open_lvl = sat_open(bus.sq_thr, HYST);
  // Modulo-2^16 subtraction gives the short-way phase step across the +/-Pi wrap.
  assign d        = bus.zi - zprev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SQ_CLOSED: if (bus.xi >= open_lvl) state_d = SQ_OPEN;
      SQ_OPEN: begin
        if (bus.xi < bus.sq_thr) begin
          state_d = SQ_HANG;
          cnt_d   = HOLD_M1;
        end
      end
      SQ_HANG: begin
        if (bus.xi >= open_lvl)  state_d = SQ_OPEN;
        else if (cnt_q == '0)    state_d = SQ_CLOSED;
        else                     cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = SQ_CLOSED;
    endcase
  end

`ifdef FM_DEEMPH_EN
  logic signed [23:0] acc_q, acc_d;
  logic signed [24:0] diff;

  // Round a[23:8] by a[7]; only positive overflow is possible, so clamp at +max.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [23:0] a);
    logic signed [DATA_W:0] r;
    r = $signed({a[23], a[23:8]}) + $signed({16'd0, a[7]});
    return (r > 17'sd32767) ? 16'sh7FFF : r[DATA_W-1:0];
  endfunction

  // The filtered value stays between acc and the target, so the 24-bit result cannot wrap.
  always_comb begin
    diff   = $signed({d[15], d, 8'h00}) - $signed({acc_q[23], acc_q});
    acc_d  = 24'($signed({acc_q[23], acc_q}) + (diff >>> K));
    fo_new = round_sat(acc_d);
  end
`else
  logic unused_k;
  assign unused_k = (K > 0);
  assign fo_new   = d;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= SQ_CLOSED;
      cnt_q    <= '0;
      zprev_q  <= '0;
      primed_q <= 1'b0;
      fo_q     <= '0;
      ao_q     <= '0;
      sq_q     <= 1'b0;
      ov_q     <= 1'b0;
`ifdef FM_DEEMPH_EN
      acc_q    <= '0;
`endif
    end else begin
      ov_q <= 1'b0;
      if (accept) begin
        zprev_q  <= bus.zi;
        primed_q <= 1'b1;
        if (primed_q) begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          ao_q    <= bus.xi;
          sq_q    <= (state_d != SQ_CLOSED);
          fo_q    <= (state_d == SQ_CLOSED) ? '0 : fo_new;
          ov_q    <= 1'b1;
`ifdef FM_DEEMPH_EN
          acc_q   <= (state_d == SQ_CLOSED) ? '0 : acc_d;
`endif
        end
      end
    end
  end

  assign bus.fo = fo_q;
  assign bus.ao = ao_q;
  assign bus.sq = sq_q;
  assign bus.ov = ov_q;
endmodule

// File: tb/tb_fm_demod16.sv
// Directed self-checking bench for fm_demod16 (HOLD=3); de-emphasis path when FM_DEEMPH_EN is defined.
module tb_fm_demod16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fm_demod16_if bus ();

  fm_demod16 #(.HOLD(3), .HYST(16'h0100), .K(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one sample for a single clock; outputs are then sampled at the following negedge.
  task automatic send(input logic [15:0] x, input logic [15:0] z, input logic m);
    bus.xi = x;
    bus.zi = z;
    bus.mi = m;
    bus.iv = 1'b1;
    @(negedge clk);
    bus.iv = 1'b0;
    bus.mi = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic ov, input logic [15:0] fo,
                            input logic [15:0] ao, input logic sq);
    chk1 ({tag, "_ov"}, bus.ov, ov);
    chk16({tag, "_fo"}, bus.fo, fo);
    chk16({tag, "_ao"}, bus.ao, ao);
    chk1 ({tag, "_sq"}, bus.sq, sq);
  endtask

  initial begin
    bus.xi = '0; bus.zi = '0; bus.mi = 1'b0; bus.iv = 1'b1; bus.sq_thr = 16'h1000;
    // Reset held for 3 clocks with iv high: reset must win
    repeat (3) @(negedge clk);
    expect_out("reset", 1'b0, 16'h0000, 16'h0000, 1'b0);
    bus.iv = 1'b0;
    rst = 1'b1;
    @(negedge clk);

`ifndef FM_DEEMPH_EN
    // Priming sample: no ov, outputs untouched
    send(16'h1200, 16'h7F00, 1'b0);
    expect_out("prime", 1'b0, 16'h0000, 16'h0000, 1'b0);
    send(16'h1200, 16'h8100, 1'b0);
    expect_out("first", 1'b1, 16'h0200, 16'h1200, 1'b1);
    @(negedge clk);
    chk1("ov_pulse_width", bus.ov, 1'b0);

    // Rotation-mode result is ignored entirely
    send(16'h0000, 16'h0000, 1'b1);
    expect_out("rotign", 1'b0, 16'h0200, 16'h1200, 1'b1);
    send(16'h1200, 16'h8300, 1'b0);
    expect_out("after_rot", 1'b1, 16'h0200, 16'h1200, 1'b1);

    // 0x8300 -> 0x7F00 wraps through +/-Pi: short-way step is -0x0400
    send(16'h1200, 16'h7F00, 1'b0);
    expect_out("wrap", 1'b1, 16'hFC00, 16'h1200, 1'b1);

    // Hang: three low samples keep squelch open, fourth closes and mutes
    send(16'h0800, 16'h8000, 1'b0);
    expect_out("hang1", 1'b1, 16'h0100, 16'h0800, 1'b1);
    send(16'h0800, 16'h8100, 1'b0);
    expect_out("hang2", 1'b1, 16'h0100, 16'h0800, 1'b1);
    send(16'h0800, 16'h8200, 1'b0);
    expect_out("hang3", 1'b1, 16'h0100, 16'h0800, 1'b1);
    send(16'h0800, 16'h8300, 1'b0);
    expect_out("closed", 1'b1, 16'h0000, 16'h0800, 1'b0);

    // Above close threshold but below open level: stays closed
    send(16'h1080, 16'h8400, 1'b0);
    expect_out("hyst", 1'b1, 16'h0000, 16'h1080, 1'b0);
    // Exactly the open level reopens; phase was tracked while muted
    send(16'h1100, 16'h8600, 1'b0);
    expect_out("reopen", 1'b1, 16'h0200, 16'h1100, 1'b1);

    // HANG -> OPEN, then counter reload on the next drop
    send(16'h0800, 16'h8700, 1'b0);
    expect_out("h2o_a", 1'b1, 16'h0100, 16'h0800, 1'b1);
    send(16'h1100, 16'h8800, 1'b0);
    expect_out("h2o_b", 1'b1, 16'h0100, 16'h1100, 1'b1);
    send(16'h0FFF, 16'h8900, 1'b0);
    chk1("reload1_sq", bus.sq, 1'b1);
    send(16'h0800, 16'h8A00, 1'b0);
    chk1("reload2_sq", bus.sq, 1'b1);
    send(16'h0800, 16'h8B00, 1'b0);
    chk1("reload3_sq", bus.sq, 1'b1);
    send(16'h0800, 16'h8C00, 1'b0);
    expect_out("reload4", 1'b1, 16'h0000, 16'h0800, 1'b0);

    // Back-to-back iv on consecutive cycles
    bus.iv = 1'b1; bus.mi = 1'b0; bus.xi = 16'h2000; bus.zi = 16'h8D00;
    @(negedge clk);
    expect_out("b2b_1", 1'b1, 16'h0100, 16'h2000, 1'b1);
    bus.zi = 16'h9000; bus.xi = 16'h2100;
    @(negedge clk);
    bus.iv = 1'b0;
    expect_out("b2b_2", 1'b1, 16'h0300, 16'h2100, 1'b1);

    // Reset coinciding with an accepted iv: no ov, everything cleared, re-prime afterwards
    bus.iv = 1'b1; bus.xi = 16'h2000; bus.zi = 16'h9100; rst = 1'b0;
    @(negedge clk);
    bus.iv = 1'b0;
    expect_out("rst_mid", 1'b0, 16'h0000, 16'h0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("rst_mid_ov_late", bus.ov, 1'b0);
    send(16'h2000, 16'h1000, 1'b0);
    expect_out("reprime", 1'b0, 16'h0000, 16'h0000, 1'b0);
    send(16'h2000, 16'h1100, 1'b0);
    expect_out("reprime_out", 1'b1, 16'h0100, 16'h2000, 1'b1);
`else
    begin
      logic [15:0] prev_fo;
      logic [15:0] z;
      z = 16'h0000;
      send(16'h2000, z, 1'b0);
      chk1("de_prime_ov", bus.ov, 1'b0);
      z = z + 16'h0100;
      send(16'h2000, z, 1'b0);
      expect_out("de_first", 1'b1, 16'h0010, 16'h2000, 1'b1);
      prev_fo = bus.fo;
      for (int i = 1; i < 200; i++) begin
        z = z + 16'h0100;
        send(16'h2000, z, 1'b0);
        checks++;
        assert ($signed(bus.fo) >= $signed(prev_fo)) else begin
          errors++;
          $error("FAIL de_mono: observed %h expected >= %h", bus.fo, prev_fo);
        end
        prev_fo = bus.fo;
      end
      checks++;
      assert (bus.fo >= 16'h00FF && bus.fo <= 16'h0101) else begin
        errors++;
        $error("FAIL de_conv: observed %h expected 0100 +/-1", bus.fo);
      end
      // Closing the squelch mutes and clears the filter
      for (int i = 0; i < 4; i++) begin
        z = z + 16'h0100;
        send(16'h0800, z, 1'b0);
      end
      expect_out("de_closed", 1'b1, 16'h0000, 16'h0800, 1'b0);
      z = z + 16'h0100;
      send(16'h2000, z, 1'b0);
      expect_out("de_reopen", 1'b1, 16'h0010, 16'h2000, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fm_demod16.md
Name: fm_demod16

Overview:
- Consumes vector-mode results from the 16-bit serial CORDIC: magnitude on X, phase on Z, plus mode and ready strobe.
- Produces an FM discriminator output (phase difference between successive samples), a registered AM/magnitude output and a carrier squelch flag with hysteresis and hang time.
- Sits directly downstream of the CORDIC in the receive path and feeds the audio filter/decimator.

Parameters:
HOLD, 1024, squelch hang time, counted in accepted samples (1..65535).
HYST, 16'h0100, squelch hysteresis added to the threshold for the open decision.
K, 4, de-emphasis shift (1..8); used only when FM_DEEMPH_EN is defined.

Ports:
clk  input  1  master clock
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
xi  input  16  CORDIC magnitude (X output); non-negative in vector mode, treated as unsigned
zi  input  16  CORDIC phase (Z output); two's complement, full scale = ±Pi
mi  input  1  CORDIC mode flag; 0 = vector result (accepted), 1 = rotation result (ignored)
iv  input  1  CORDIC ready strobe; one-cycle pulse per result
sq_thr  input  16  squelch close threshold, unsigned; sampled on each accepted sample
fo  output  16  frequency/discriminator output, signed
ao  output  16  magnitude output, unsigned
sq  output  1  squelch open (1 = carrier present)
ov  output  1  output valid; one-cycle pulse

Behaviour:
- Reset (rst=0 at a clock edge):
  - fo=0, ao=0, sq=0, ov=0.
  - Previous-phase register = 0; primed flag = 0; hang counter = 0; squelch state = CLOSED; de-emphasis accumulator = 0.
  - Reset wins over a simultaneous iv.
- Accept condition: iv=1 and mi=0. Samples with iv=1 and mi=1 are ignored entirely: no state change, no ov.
- Latency: ov pulses exactly one clock after an accepted iv. fo, ao and sq update in that same cycle and hold until the next ov.
- Priming:
  - The first accepted sample after reset only loads the previous-phase register and sets primed. No ov is generated.
  - Every later accepted sample produces ov.
- Discriminator: d = zi - zprev, computed as a 16-bit modulo-2^16 difference, so phase wrap at ±Pi yields the short-way signed result. zprev <= zi on every accepted sample.
- Magnitude: ao <= xi on every accepted sample after priming.
- Squelch FSM, evaluated on each accepted primed sample. Open level = min(sq_thr + HYST, 16'hFFFF), with the add done at 17 bits and saturated.
  - CLOSED -> OPEN when xi >= open level; otherwise stay in CLOSED.
  - OPEN -> HANG when xi < sq_thr; hang counter loaded with HOLD-1.
  - HANG -> OPEN when xi >= open level.
  - In HANG, on each accepted sample with xi below the open level: if counter = 0 go to CLOSED, else decrement.
  - sq = 1 in OPEN and HANG, 0 in CLOSED. sq reflects the state after the current sample's transition.
- Muting: when the post-transition state is CLOSED, fo = 0. Phase tracking continues so there is no click on reopen.
- fo without FM_DEEMPH_EN: fo = d.
- Back-to-back: iv pulses are at least 40 clocks apart from the CORDIC. The block nevertheless accepts iv on consecutive cycles with correct results.

Optional Feature:
FM_DEEMPH_EN
- Defined: single-pole de-emphasis.
  - 24-bit signed accumulator a: a <= a + ((({d,8'h00}) - a) >>> K) on each primed accepted sample while not CLOSED.
  - fo = a[23:8], rounded: add a[7] with saturation.
  - When CLOSED, a is cleared to 0 and fo = 0.
- Undefined: fo = d directly. No accumulator is built.

Test Plan:
- Reset with rst=0 for 3 clocks, then iv pulses with mi=0 -> all outputs 0; the first accepted sample produces no ov; ov appears on the second accepted sample, 1 clock after its iv.
- sq_thr=0x1000, HYST default, xi=0x1200, zi sequence 0x7F00 then 0x8100 (no deemph) -> sq=1, fo=0x0200, ao=0x1200.
- Squelch open at xi=0x1200, then xi=0x0800 with HOLD=3 -> sq stays 1 for 3 accepted samples with fo active; on the 4th low sample sq=0 and fo=0. xi=0x1080 while CLOSED -> stays closed (below 0x1100).
- iv=1 with mi=1 interleaved between vector samples -> no ov, zprev unchanged; the next vector sample's fo equals the difference from the last vector sample.
- rst asserted low between an iv pulse and its ov -> ov is not asserted; after release the next accepted sample re-primes and generates no ov.
- FM_DEEMPH_EN with K=4, constant d=0x0100 on an open squelch -> fo rises monotonically: 0x0010 after the 1st output, converging to 0x0100 within ±1 LSB after 200 samples.
